// File: rtl/mips_pkg.sv
// Shared widths, opcode encodings and the ID/EX pipeline payload.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned ALU_W  = 3;
  localparam int unsigned JZ_W   = 2;
  localparam int unsigned CTRL_W = 4;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_OR  = 3'd2,
    ALU_LUI = 3'd3,
    ALU_XOR = 3'd4
  } aluctr_e;

  typedef enum logic [JZ_W-1:0] {
    JZ_ALWAYS = 2'd0,
    JZ_EQ     = 2'd1,
    JZ_NEVER  = 2'd2
  } jzero_e;

  // Bit positions inside id_ctrl = {alusrc, regwrite, memwrite, memtoreg}
  localparam int unsigned CTRL_ALUSRC   = 3;
  localparam int unsigned CTRL_REGWRITE = 2;
  localparam int unsigned CTRL_MEMWRITE = 1;
  localparam int unsigned CTRL_MEMTOREG = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] waddr;
    logic [ALU_W-1:0]  aluctr;
    logic [JZ_W-1:0]   jzero;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

  // Bubble: ADD, never-branch, no side effects, all data zero
  function automatic id_ex_t id_ex_bubble();
    id_ex_t b;
    b        = '0;
    b.aluctr = ALU_W'(ALU_ADD);
    b.jzero  = JZ_W'(JZ_NEVER);
    return b;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// One 32-bit operand forwarder: MEM result beats WB result beats the
// registered value; register 0 is never forwarded.
// Only built when MIPS_FWD_EN is defined.
`ifdef MIPS_FWD_EN
module fwd_mux
  import mips_pkg::*;
(
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [DATA_W-1:0] i_reg_data,
  input  logic              i_mem_regwrite,
  input  logic [ADDR_W-1:0] i_mem_waddr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  input  logic              i_wb_regwrite,
  input  logic [ADDR_W-1:0] i_wb_waddr,
  input  logic [DATA_W-1:0] i_wb_wdata,
  output logic [DATA_W-1:0] o_data
);

  logic w_src_nz;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_src_nz  = (i_src_addr != '0);
  assign w_mem_hit = w_src_nz && i_mem_regwrite && (i_mem_waddr == i_src_addr);
  assign w_wb_hit  = w_src_nz && i_wb_regwrite && (i_wb_waddr == i_src_addr);

  // Priority select of the operand source
  always_comb begin
    o_data = i_reg_data;
    if (w_mem_hit) begin
      o_data = i_mem_wdata;
    end else if (w_wb_hit) begin
      o_data = i_wb_wdata;
    end
  end

endmodule
`endif

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// MIPS_FWD_EN: enables MEM/WB forwarding and the memtoreg-only load-use
// check; without it operands come straight from the registers and any
// pending register write in EX that matches an ID source requests a stall.
module id_ex_reg
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm32,
  input  logic [ADDR_W-1:0] id_waddr,
  input  logic [ALU_W-1:0]  id_aluctr,
  input  logic [JZ_W-1:0]   id_jzero,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              mem_regwrite,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic [ALU_W-1:0]  ALUctr,
  output logic [DATA_W-1:0] SrcA,
  output logic [DATA_W-1:0] SrcB,
  output logic [JZ_W-1:0]   j_zero,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [ADDR_W-1:0] ex_waddr,
  output logic [2:0]        ex_ctrl,
  output logic              hz_stall
);

  id_ex_t            r_ex;
  id_ex_t            w_ex_next;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic              w_hz_kind;

  // Next pipeline contents: flush beats stall, stall holds, else capture
  always_comb begin
    w_ex_next = r_ex;
    if (flush) begin
      w_ex_next = id_ex_bubble();
    end else if (!stall) begin
      w_ex_next.rs_addr = id_rs_addr;
      w_ex_next.rt_addr = id_rt_addr;
      w_ex_next.rs_data = id_rs_data;
      w_ex_next.rt_data = id_rt_data;
      w_ex_next.imm     = id_imm32;
      w_ex_next.waddr   = id_waddr;
      w_ex_next.aluctr  = id_aluctr;
      w_ex_next.jzero   = id_jzero;
      w_ex_next.ctrl    = id_ctrl;
    end
  end

  // Pipeline register; reset loads the bubble immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex <= id_ex_bubble();
    end else begin
      r_ex <= w_ex_next;
    end
  end

`ifdef MIPS_FWD_EN
  fwd_mux u_fwd_rs (
    .i_src_addr     (r_ex.rs_addr),
    .i_reg_data     (r_ex.rs_data),
    .i_mem_regwrite (mem_regwrite),
    .i_mem_waddr    (mem_waddr),
    .i_mem_wdata    (mem_wdata),
    .i_wb_regwrite  (wb_regwrite),
    .i_wb_waddr     (wb_waddr),
    .i_wb_wdata     (wb_wdata),
    .o_data         (w_rs_val)
  );

  fwd_mux u_fwd_rt (
    .i_src_addr     (r_ex.rt_addr),
    .i_reg_data     (r_ex.rt_data),
    .i_mem_regwrite (mem_regwrite),
    .i_mem_waddr    (mem_waddr),
    .i_mem_wdata    (mem_wdata),
    .i_wb_regwrite  (wb_regwrite),
    .i_wb_waddr     (wb_waddr),
    .i_wb_wdata     (wb_wdata),
    .o_data         (w_rt_val)
  );

  // Only a load in EX cannot be forwarded in time
  assign w_hz_kind = r_ex.ctrl[CTRL_MEMTOREG];
`else
  logic w_unused_nofwd;

  assign w_rs_val  = r_ex.rs_data;
  assign w_rt_val  = r_ex.rt_data;
  // Without forwarding any pending write in EX is a hazard
  assign w_hz_kind = r_ex.ctrl[CTRL_REGWRITE];
  assign w_unused_nofwd = ^{mem_regwrite, mem_waddr, mem_wdata,
                            wb_regwrite, wb_waddr, wb_wdata,
                            r_ex.rs_addr, r_ex.rt_addr};
`endif

  // Hazard request toward IF/ID
  always_comb begin
    hz_stall = 1'b0;
    if (w_hz_kind && (r_ex.waddr != '0) &&
        ((r_ex.waddr == id_rs_addr) || (r_ex.waddr == id_rt_addr))) begin
      hz_stall = 1'b1;
    end
  end

  // Second ALU operand: immediate or forwarded rt
  always_comb begin
    SrcB = w_rt_val;
    if (r_ex.ctrl[CTRL_ALUSRC]) begin
      SrcB = r_ex.imm;
    end
  end

  assign SrcA          = w_rs_val;
  assign ex_store_data = w_rt_val;
  assign ALUctr        = r_ex.aluctr;
  assign j_zero        = r_ex.jzero;
  assign ex_waddr      = r_ex.waddr;
  assign ex_ctrl       = {r_ex.ctrl[CTRL_REGWRITE], r_ex.ctrl[CTRL_MEMWRITE],
                          r_ex.ctrl[CTRL_MEMTOREG]};

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: driver predicts, monitor compares.
module tb_id_ex_reg;

`ifdef MIPS_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [4:0]  id_rs_addr, id_rt_addr, id_waddr;
  logic [31:0] id_rs_data, id_rt_data, id_imm32;
  logic [2:0]  id_aluctr;
  logic [1:0]  id_jzero;
  logic [3:0]  id_ctrl;
  logic        mem_regwrite, wb_regwrite;
  logic [4:0]  mem_waddr, wb_waddr;
  logic [31:0] mem_wdata, wb_wdata;
  logic [2:0]  ALUctr;
  logic [31:0] SrcA, SrcB, ex_store_data;
  logic [1:0]  j_zero;
  logic [4:0]  ex_waddr;
  logic [2:0]  ex_ctrl;
  logic        hz_stall;

  id_ex_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm32(id_imm32), .id_waddr(id_waddr), .id_aluctr(id_aluctr),
    .id_jzero(id_jzero), .id_ctrl(id_ctrl),
    .mem_regwrite(mem_regwrite), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_regwrite(wb_regwrite), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ALUctr(ALUctr), .SrcA(SrcA), .SrcB(SrcB), .j_zero(j_zero),
    .ex_store_data(ex_store_data), .ex_waddr(ex_waddr), .ex_ctrl(ex_ctrl),
    .hz_stall(hz_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic stall, flush;
    logic [4:0] rs, rt, wa;
    logic [31:0] rsd, rtd, imm;
    logic [2:0] alu;
    logic [1:0] jz;
    logic [3:0] ctrl;
    logic mrw; logic [4:0] mwa; logic [31:0] mwd;
    logic wrw; logic [4:0] wwa; logic [31:0] wwd;
  } stim_t;

  // Architectural view of what the EX stage currently holds
  typedef struct {
    logic [4:0] rs, rt, wa;
    logic [31:0] a, b, imm;
    logic [2:0] alu;
    logic [1:0] jz;
    logic alusrc, rw, mw, m2r;
  } mdl_t;

  typedef struct {
    string tag;
    logic [2:0] alu;
    logic [31:0] srca, srcb, store;
    logic [1:0] jz;
    logic [4:0] wa;
    logic [2:0] ctrl;
    logic hz;
  } exp_t;

  exp_t  q[$];
  mdl_t  mdl;
  stim_t cur;
  int    total = 0;
  int    bad = 0;
  event  mon_ev;

  function automatic stim_t nop();
    stim_t s;
    s.stall = 0; s.flush = 0; s.rs = 0; s.rt = 0; s.wa = 0;
    s.rsd = 0; s.rtd = 0; s.imm = 0; s.alu = 0; s.jz = 0; s.ctrl = 0;
    s.mrw = 0; s.mwa = 0; s.mwd = 0; s.wrw = 0; s.wwa = 0; s.wwd = 0;
    return s;
  endfunction

  function automatic mdl_t bubble_m();
    mdl_t m;
    m.rs = 0; m.rt = 0; m.wa = 0; m.a = 0; m.b = 0; m.imm = 0;
    m.alu = 0; m.jz = 2; m.alusrc = 0; m.rw = 0; m.mw = 0; m.m2r = 0;
    return m;
  endfunction

  function automatic mdl_t step(mdl_t m, stim_t s);
    mdl_t n;
    if (s.flush) return bubble_m();
    if (s.stall) return m;
    n.rs = s.rs; n.rt = s.rt; n.wa = s.wa; n.a = s.rsd; n.b = s.rtd;
    n.imm = s.imm; n.alu = s.alu; n.jz = s.jz;
    n.alusrc = s.ctrl[3]; n.rw = s.ctrl[2]; n.mw = s.ctrl[1]; n.m2r = s.ctrl[0];
    return n;
  endfunction

  // Value an EX operand actually sees given the buses in flight
  function automatic logic [31:0] operand(logic [4:0] r, logic [31:0] v, stim_t s);
    if (FWD && r != 0 && s.mrw && s.mwa == r) return s.mwd;
    if (FWD && r != 0 && s.wrw && s.wwa == r) return s.wwd;
    return v;
  endfunction

  function automatic exp_t predict(mdl_t m, stim_t s, string tag);
    exp_t e;
    logic hazard_src;
    e.tag   = tag;
    e.alu   = m.alu;
    e.jz    = m.jz;
    e.wa    = m.wa;
    e.ctrl  = {m.rw, m.mw, m.m2r};
    e.srca  = operand(m.rs, m.a, s);
    e.store = operand(m.rt, m.b, s);
    e.srcb  = m.alusrc ? m.imm : e.store;
    hazard_src = FWD ? m.m2r : m.rw;
    e.hz = hazard_src && (m.wa != 0) && (m.wa == s.rs || m.wa == s.rt);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input stim_t s);
    cur = s;
    stall = s.stall; flush = s.flush;
    id_rs_addr = s.rs; id_rt_addr = s.rt; id_waddr = s.wa;
    id_rs_data = s.rsd; id_rt_data = s.rtd; id_imm32 = s.imm;
    id_aluctr = s.alu; id_jzero = s.jz; id_ctrl = s.ctrl;
    mem_regwrite = s.mrw; mem_waddr = s.mwa; mem_wdata = s.mwd;
    wb_regwrite = s.wrw; wb_waddr = s.wwa; wb_wdata = s.wwd;
  endtask

  // One clock: drive at negedge, predict, let the monitor check after posedge
  task automatic cycle(input stim_t s, input string tag);
    @(negedge clk);
    apply(s);
    mdl = step(mdl, s);
    q.push_back(predict(mdl, s, tag));
    @(posedge clk);
    #1;
    ->mon_ev;
  endtask

  // Monitor: pops the oldest expectation whenever outputs are sampled
  initial begin
    exp_t e;
    forever begin
      @(mon_ev);
      if (q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk({e.tag, ".ALUctr"}, 32'(ALUctr), 32'(e.alu));
        chk({e.tag, ".SrcA"}, SrcA, e.srca);
        chk({e.tag, ".SrcB"}, SrcB, e.srcb);
        chk({e.tag, ".j_zero"}, 32'(j_zero), 32'(e.jz));
        chk({e.tag, ".store"}, ex_store_data, e.store);
        chk({e.tag, ".ex_waddr"}, 32'(ex_waddr), 32'(e.wa));
        chk({e.tag, ".ex_ctrl"}, 32'(ex_ctrl), 32'(e.ctrl));
        chk({e.tag, ".hz_stall"}, 32'(hz_stall), 32'(e.hz));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    reset = 1'b0;
    apply(nop());
    mdl = bubble_m();
    #2 reset = 1'b1;
    q.push_back(predict(mdl, cur, "reset"));
    #1 ->mon_ev;
    @(negedge clk);
    reset = 1'b0;

    // Plain capture, one-cycle latency
    s = nop(); s.rs = 1; s.rt = 2; s.rsd = 5; s.rtd = 7; s.alu = 1;
    cycle(s, "capture");
    // Immediate operand on B, rt still on store path
    s = nop(); s.rs = 3; s.rt = 4; s.rsd = 32'h10; s.rtd = 32'h20;
    s.imm = 32'h1234; s.ctrl = 4'b1010; s.alu = 2; s.jz = 1; s.wa = 6;
    cycle(s, "alusrc");
    // MEM beats WB on the same register
    s = nop(); s.rs = 8; s.rsd = 32'h11; s.rt = 8; s.rtd = 32'h22;
    s.mrw = 1; s.mwa = 8; s.mwd = 32'hAA; s.wrw = 1; s.wwa = 8; s.wwd = 32'hBB;
    cycle(s, "prio_mem");
    s.mrw = 0;
    cycle(s, "prio_wb");
    // Register 0 never forwarded
    s = nop(); s.rs = 0; s.rsd = 0; s.mrw = 1; s.mwa = 0; s.mwd = 32'hFF;
    s.wrw = 1; s.wwa = 0; s.wwd = 32'hEE;
    cycle(s, "reg0");
    // Load into $9 enters EX, then ID reads $9 while stalled
    s = nop(); s.ctrl = 4'b0101; s.wa = 9; s.rsd = 32'h40; s.imm = 4;
    cycle(s, "load");
    s = nop(); s.stall = 1; s.rt = 9; s.rs = 3; s.rtd = 32'h99;
    cycle(s, "load_use");
    // Stall together with flush: bubble wins
    s.flush = 1;
    cycle(s, "stall_flush");
    // Hold under stall with changing inputs
    s = nop(); s.rs = 5; s.rsd = 32'hCAFE; s.alu = 4; s.ctrl = 4'b0100; s.wa = 7;
    cycle(s, "pre_hold");
    s = nop(); s.stall = 1; s.rsd = 32'hDEAD; s.alu = 3; s.wa = 2; s.rs = 7;
    cycle(s, "hold");
    // Async reset between edges while stalled
    #2 reset = 1'b1;
    mdl = bubble_m();
    q.push_back(predict(mdl, cur, "rst_mid"));
    #1 ->mon_ev;
    @(negedge clk);
    reset = 1'b0;
    cycle(s, "post_rst");

    // Randomized traffic over a small register window to provoke matches
    for (int i = 0; i < 400; i++) begin
      s = nop();
      s.stall = ($urandom_range(0, 3) == 0);
      s.flush = ($urandom_range(0, 7) == 0);
      s.rs  = 5'($urandom_range(0, 3));
      s.rt  = 5'($urandom_range(0, 3));
      s.wa  = 5'($urandom_range(0, 3));
      s.rsd = $urandom; s.rtd = $urandom; s.imm = $urandom;
      s.alu = 3'($urandom_range(0, 4));
      s.jz  = 2'($urandom_range(0, 2));
      s.ctrl = 4'($urandom_range(0, 15));
      s.mrw = 1'($urandom_range(0, 1));
      s.mwa = 5'($urandom_range(0, 3));
      s.mwd = $urandom;
      s.wrw = 1'($urandom_range(0, 1));
      s.wwa = 5'($urandom_range(0, 3));
      s.wwd = $urandom;
      cycle(s, "rand");
    end

    @(negedge clk);
    chk("sb_leftover", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
